// File: rtl/part_74s181.sv
// part_74s181: 4-bit ALU / function generator modelled on the 74S181.
// Sixteen logic functions (M=1) or sixteen arithmetic functions (M=0) of A and B,
// with active-low carry out and group propagate/generate outputs for a 74S182
// lookahead unit. REGISTERED=0 is purely combinational, like the TTL part;
// REGISTERED=1 places a register stage on every output.
module part_74s181 #(
    parameter bit REGISTERED = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic A3,
    input  logic A2,
    input  logic A1,
    input  logic A0,
    input  logic B3,
    input  logic B2,
    input  logic B1,
    input  logic B0,
    input  logic S3,
    input  logic S2,
    input  logic S1,
    input  logic S0,
    input  logic M,
    input  logic CIN_N,
    output logic F3,
    output logic F2,
    output logic F1,
    output logic F0,
    output logic COUT_N,
    output logic X,
    output logic Y,
    output logic AEB
);

    typedef struct packed {
        logic [3:0] f;
        logic       cout_n;
        logic       x;
        logic       y;
        logic       aeb;
    } alu_out_t;

    // Output state while reset is held: F cleared, active-low flags inactive.
    localparam alu_out_t RESET_OUT = '{f: 4'b0000, cout_n: 1'b1, x: 1'b1, y: 1'b1, aeb: 1'b0};

    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] carry;
    logic       c0;
    logic       c4;
    logic       group_gen;
    logic [3:0] f_arith;
    logic [3:0] f_logic;
    alu_out_t   comb_out;
    alu_out_t   out;

    assign a = {A3, A2, A1, A0};
    assign b = {B3, B2, B1, B0};
    assign s = {S3, S2, S1, S0};

    // Per-bit propagate and generate; S selects which minterms of A,B feed each.
    assign p = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign g = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});

    // Flattened carry lookahead, the same two-level structure as the real part,
    // so no carry depends on another carry signal.
    assign c0       = ~CIN_N;
    assign carry[0] = c0;
    assign carry[1] = g[0] | (p[0] & c0);
    assign carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c0);

    assign group_gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]);
    assign c4        = group_gen | ((&p) & c0);

    // Arithmetic mode is the sum P + G + c0; logic mode ignores the carries.
    assign f_arith = p ^ g ^ carry;
    assign f_logic = ~(p ^ g);

    // Combine mode-dependent F with the mode-independent lookahead outputs.
    always_comb begin
        comb_out        = RESET_OUT;
        comb_out.f      = M ? f_logic : f_arith;
        comb_out.cout_n = ~c4;
        comb_out.x      = ~(&p);
        comb_out.y      = ~group_gen;
        comb_out.aeb    = &comb_out.f;
    end

    generate
        if (REGISTERED) begin : g_reg
            // Output register: async clear on reset, load current function on rising clk.
            // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out <= RESET_OUT;
                end else begin
                    out <= comb_out;
                end
            end
        end else begin : g_comb
            // Clock and reset have no function in the combinational build.
            logic unused_clk_reset;
            assign unused_clk_reset = clk | reset;
            assign out = comb_out;
        end
    endgenerate

    assign {F3, F2, F1, F0} = out.f;
    assign COUT_N           = out.cout_n;
    assign X                = out.x;
    assign Y                = out.y;
    assign AEB              = out.aeb;

endmodule

// File: tb/tb_part_74s181.sv
// Bench for part_74s181: drives a combinational and a registered instance with
// the same inputs; expected responses are queued at stimulus time and a monitor
// on the falling clock edge pops and compares them.
module tb_part_74s181;

    typedef struct {
        logic [7:0] val;   // {F[3:0], COUT_N, X, Y, AEB}
        logic [7:0] care;
        string      name;
    } exp_t;

    localparam logic [7:0] RST_VAL = 8'b0000_1110;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] a, b, s;
    logic m, cin_n;

    logic [3:0] f_c, f_r;
    logic cout_n_c, x_c, y_c, aeb_c;
    logic cout_n_r, x_r, y_r, aeb_r;

    exp_t q_comb[$];
    exp_t q_reg[$];
    bit   mon_en    = 1'b0;
    bit   stim_done = 1'b0;
    int   n_checks  = 0;
    int   n_pass    = 0;

    always #5 clk = ~clk;

    part_74s181 #(.REGISTERED(1'b0)) dut_c (
        .clk(clk), .reset(reset),
        .A3(a[3]), .A2(a[2]), .A1(a[1]), .A0(a[0]),
        .B3(b[3]), .B2(b[2]), .B1(b[1]), .B0(b[0]),
        .S3(s[3]), .S2(s[2]), .S1(s[1]), .S0(s[0]),
        .M(m), .CIN_N(cin_n),
        .F3(f_c[3]), .F2(f_c[2]), .F1(f_c[1]), .F0(f_c[0]),
        .COUT_N(cout_n_c), .X(x_c), .Y(y_c), .AEB(aeb_c)
    );

    part_74s181 #(.REGISTERED(1'b1)) dut_r (
        .clk(clk), .reset(reset),
        .A3(a[3]), .A2(a[2]), .A1(a[1]), .A0(a[0]),
        .B3(b[3]), .B2(b[2]), .B1(b[1]), .B0(b[0]),
        .S3(s[3]), .S2(s[2]), .S1(s[1]), .S0(s[0]),
        .M(m), .CIN_N(cin_n),
        .F3(f_r[3]), .F2(f_r[2]), .F1(f_r[1]), .F0(f_r[0]),
        .COUT_N(cout_n_r), .X(x_r), .Y(y_r), .AEB(aeb_r)
    );

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req, input logic [7:0] care);
        n_checks++;
        if (((act ^ req) & care) === 8'h00) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b want %b (care %b)", name, act, req, care);
        end
    endtask

    // Reference model built from the function tables and integer arithmetic.
    function automatic logic [7:0] model(input logic [3:0] ai, input logic [3:0] bi,
                                         input logic [3:0] si, input logic mi,
                                         input logic cin_ni);
        logic [3:0] pv, gv, fv;
        int c, av, bv, sum, pg;
        pv  = ai | (bi & {4{si[0]}}) | (~bi & {4{si[1]}});
        gv  = (ai & bi & {4{si[3]}}) | (ai & ~bi & {4{si[2]}});
        c   = cin_ni ? 0 : 1;
        av  = int'(ai);
        bv  = int'(bi);
        pg  = int'(pv) + int'(gv);
        sum = pg + c;
        if (mi) begin
            case (si)
                4'd0:  fv = ~ai;
                4'd1:  fv = ~(ai | bi);
                4'd2:  fv = ~ai & bi;
                4'd3:  fv = 4'b0000;
                4'd4:  fv = ~(ai & bi);
                4'd5:  fv = ~bi;
                4'd6:  fv = ai ^ bi;
                4'd7:  fv = ai & ~bi;
                4'd8:  fv = ~ai | bi;
                4'd9:  fv = ~(ai ^ bi);
                4'd10: fv = bi;
                4'd11: fv = ai & bi;
                4'd12: fv = 4'b1111;
                4'd13: fv = ai | ~bi;
                4'd14: fv = ai | bi;
                default: fv = ai;
            endcase
        end else begin
            int r;
            case (si)
                4'd0:  r = av;
                4'd1:  r = int'(ai | bi);
                4'd2:  r = int'(ai | ~bi);
                4'd3:  r = 15;
                4'd4:  r = av + int'(ai & ~bi);
                4'd5:  r = int'(ai | bi) + int'(ai & ~bi);
                4'd6:  r = av - bv - 1;
                4'd7:  r = int'(ai & ~bi) - 1;
                4'd8:  r = av + int'(ai & bi);
                4'd9:  r = av + bv;
                4'd10: r = int'(ai | ~bi) + int'(ai & bi);
                4'd11: r = int'(ai & bi) - 1;
                4'd12: r = av + av;
                4'd13: r = int'(ai | bi) + av;
                4'd14: r = int'(ai | ~bi) + av;
                default: r = av - 1;
            endcase
            r  = (r + c) & 15;
            fv = r[3:0];
        end
        return {fv, (sum < 16), (pv != 4'hF), (pg < 16), (fv == 4'hF)};
    endfunction

    // Apply one vector; queue the model result plus an optional spec-given
    // expectation (masked to the outputs the spec names).
    task automatic apply(input logic [3:0] ai, input logic [3:0] bi, input logic [3:0] si,
                         input logic mi, input logic cin_ni, input string name,
                         input logic [7:0] sval, input logic [7:0] scare);
        exp_t e;
        @(posedge clk);
        #1;
        a = ai; b = bi; s = si; m = mi; cin_n = cin_ni;
        e.val  = model(ai, bi, si, mi, cin_ni);
        e.care = 8'hFF;
        e.name = name;
        if (scare != 8'h00) begin
            // Spec-stated values override the model where given.
            e.val = (e.val & ~scare) | (sval & scare);
        end
        q_comb.push_back(e);
        q_reg.push_back(e);
        mon_en = 1'b1;
    endtask

    // Monitor: compare both instances against their queues away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q_comb.size() > 0) begin
                exp_t e;
                e = q_comb.pop_front();
                check({"comb ", e.name}, {f_c, cout_n_c, x_c, y_c, aeb_c}, e.val, e.care);
            end else if (!stim_done) begin
                check("comb underflow", 8'h01, 8'h00, 8'hFF);
            end
            if (q_reg.size() >= 2 || (stim_done && q_reg.size() >= 1)) begin
                exp_t e;
                e = q_reg.pop_front();
                check({"reg ", e.name}, {f_r, cout_n_r, x_r, y_r, aeb_r}, e.val, e.care);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sweep_f [16];
        logic [7:0] exp_v;
        sweep_f = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
                    4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};

        reset = 1'b1;
        a = 4'hF; b = 4'h0; s = 4'h0; m = 1'b0; cin_n = 1'b1;
        #3;
        check("reset state", {f_r, cout_n_r, x_r, y_r, aeb_r}, RST_VAL, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first clk after reset", {f_r, cout_n_r, x_r, y_r, aeb_r},
              8'b1111_1011, 8'hFF);

        // Directed cases, A=1111 B=0000 CIN_N=1 unless noted.
        apply(4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, "A",        8'b1111_1011, 8'hFF);
        apply(4'hF, 4'h0, 4'b1100, 1'b0, 1'b1, "A+A",      8'b1110_0000, 8'hF5);
        apply(4'hF, 4'h0, 4'b0110, 1'b0, 1'b1, "A-B-1",    8'b1110_0000, 8'hF8);
        apply(4'h5, 4'h5, 4'b0110, 1'b0, 1'b1, "A-B-1 eq", 8'b1111_0001, 8'hF1);
        apply(4'h7, 4'h1, 4'b1001, 1'b0, 1'b1, "A+B",      8'b1000_1000, 8'hF8);
        apply(4'h7, 4'h1, 4'b1001, 1'b0, 1'b0, "A+B+1",    8'b1001_1000, 8'hF8);
        apply(4'hF, 4'h1, 4'b1001, 1'b0, 1'b1, "A+B wrap", 8'b0000_0000, 8'hF8);
        for (int i = 0; i < 16; i++) begin
            apply(4'hF, 4'h0, 4'(i), 1'b1, 1'b1, $sformatf("logic sweep S=%0d", i),
                  {sweep_f[i], 4'b0000}, 8'hF0);
        end

        // Randomized vectors covering both modes and both carry-in values.
        for (int i = 0; i < 400; i++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $sformatf("rand %0d", i), 8'h00, 8'h00);
        end

        // Drain the registered pipeline, then stop the monitor.
        @(posedge clk);
        #1;
        stim_done = 1'b1;
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("queues drained", 8'(q_comb.size() + q_reg.size()), 8'h00, 8'hFF);

        // Reset asserted mid-cycle clears registered outputs without a clock edge.
        @(posedge clk);
        #1;
        a = 4'h7; b = 4'h1; s = 4'b1001; m = 1'b0; cin_n = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid-cycle reset", {f_r, cout_n_r, x_r, y_r, aeb_r}, RST_VAL, 8'hFF);
        @(posedge clk);
        #1;
        check("reset held over clk", {f_r, cout_n_r, x_r, y_r, aeb_r}, RST_VAL, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        a = 4'h3; b = 4'hC; s = 4'b0110; m = 1'b1; cin_n = 1'b1;
        #1;
        check("no load before clk", {f_r, cout_n_r, x_r, y_r, aeb_r}, RST_VAL, 8'hFF);
        exp_v = model(4'h3, 4'hC, 4'b0110, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("load after release", {f_r, cout_n_r, x_r, y_r, aeb_r}, exp_v, 8'hFF);
        check("A^B after release", {f_r, 4'b0000}, 8'b1111_0000, 8'hF0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
